// File: rtl/axis_ifmaps_rx_fifo_if.sv
// AXI4-Stream beat bundle between the DMA stream and the ifmaps ingress FIFO.
interface axis_ifmaps_rx_fifo_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_ifmaps_rx_fifo.sv
// Show-ahead ingress word FIFO for ifmaps beats, with vector framing check and
// completed-vector counter.
module axis_ifmaps_rx_fifo #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int MAC_NUM              = 256,
  parameter int FIFO_DEPTH           = 64,
  localparam int WORDS_PER_VEC       = 5 * MAC_NUM / C_S_AXIS_TDATA_WIDTH,
  localparam int PTR_W               = $clog2(FIFO_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  axis_ifmaps_rx_fifo_if.slave            s_axis,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_dout,
  output logic                            fifo_empty,
  input  logic                            fifo_read,
  output logic [PTR_W:0]                  fifo_level,
  output logic [15:0]                     vec_cnt,
  output logic                            len_err,
  input  logic                            err_clr
);

  localparam int W      = C_S_AXIS_TDATA_WIDTH;
  localparam int BEAT_W = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
  localparam logic [PTR_W:0]    FULL_LVL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    ZERO_LVL  = {(PTR_W+1){1'b0}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_VEC - 1);

  logic [W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    level_q, level_d;
  logic [W-1:0]      dout_q, dout_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [15:0]       vec_q, vec_d;
  logic              err_q, err_d;
  logic              rdy_q;
  logic              wr, rd, vec_inc, frm_err;

  assign s_axis.tready = rdy_q & (level_q != FULL_LVL);
  assign fifo_dout     = dout_q;
  assign fifo_empty    = (level_q == ZERO_LVL);
  assign fifo_level    = level_q;
  assign vec_cnt       = vec_q;
  assign len_err       = err_q;

  always_comb begin
    wr       = s_axis.tvalid & s_axis.tready;
    rd       = fifo_read & (level_q != ZERO_LVL);
    wr_ptr_d = wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    if (wr && !rd) begin
      level_d = level_q + (PTR_W+1)'(1);
    end else if (rd && !wr) begin
      level_d = level_q - (PTR_W+1)'(1);
    end else begin
      level_d = level_q;
    end

    // Head register: a word written into a drained FIFO becomes the head directly.
    if (level_d == ZERO_LVL) begin
      dout_d = dout_q;
    end else if (wr && (wr_ptr_q == rd_ptr_d)) begin
      dout_d = s_axis.tdata;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end

    vec_inc = 1'b0;
    frm_err = 1'b0;
    if (wr) begin
      if (beat_q == LAST_BEAT) begin
        beat_d  = {BEAT_W{1'b0}};
        vec_inc = 1'b1;
      end else if (s_axis.tlast) begin
        beat_d  = {BEAT_W{1'b0}};
        frm_err = 1'b1;
      end else begin
        beat_d  = beat_q + BEAT_W'(1);
      end
    end else begin
      beat_d = beat_q;
    end

    if (err_clr) begin
      vec_d = 16'h0000;
      err_d = 1'b0;
    end else begin
      vec_d = (vec_inc && (vec_q != 16'hFFFF)) ? vec_q + 16'h0001 : vec_q;
      err_d = err_q | frm_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= ZERO_LVL;
      dout_q   <= {W{1'b0}};
      beat_q   <= {BEAT_W{1'b0}};
      vec_q    <= 16'h0000;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wr_ptr_q] <= s_axis.tdata;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      beat_q   <= beat_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      rdy_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_ifmaps_rx_fifo.sv
// Scoreboard bench for axis_ifmaps_rx_fifo: a behavioural occupancy/framing model
// is advanced every cycle and compared against the DUT outputs.
module tb_axis_ifmaps_rx_fifo;
  localparam int W     = 32;
  localparam int DEPTH = 64;
  localparam int WPV   = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_read;
  logic [6:0]   fifo_level;
  logic [15:0]  vec_cnt;
  logic         len_err;
  logic         err_clr;

  axis_ifmaps_rx_fifo_if #(.DATA_W(W)) s_axis ();

  axis_ifmaps_rx_fifo #(
    .C_S_AXIS_TDATA_WIDTH(W),
    .MAC_NUM(256),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis(s_axis),
    .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_read(fifo_read),
    .fifo_level(fifo_level),
    .vec_cnt(vec_cnt),
    .len_err(len_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];
  bit          rel;
  int          beat;
  logic [15:0] vcnt;
  bit          lerr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs with the model, advance the model, clock.
  task automatic step(output bit acc);
    int lvl;
    bit wr_e, rd_e, inc, er;
    lvl = sb.size();
    check("tready", 32'(s_axis.tready), 32'(rel && (lvl != DEPTH)));
    check("empty", 32'(fifo_empty), 32'(lvl == 0));
    check("level", 32'(fifo_level), 32'(lvl));
    check("vec_cnt", 32'(vec_cnt), 32'(vcnt));
    check("len_err", 32'(len_err), 32'(lerr));
    if (lvl != 0) check("head", fifo_dout, sb[0]);
    wr_e = s_axis.tvalid && rel && (lvl != DEPTH);
    rd_e = fifo_read && (lvl != 0);
    inc  = 1'b0;
    er   = 1'b0;
    if (rd_e) void'(sb.pop_front());
    if (wr_e) begin
      sb.push_back(s_axis.tdata);
      if (beat == WPV - 1) begin
        beat = 0;
        inc  = 1'b1;
      end else if (s_axis.tlast) begin
        beat = 0;
        er   = 1'b1;
      end else begin
        beat++;
      end
    end
    if (err_clr) begin
      vcnt = 16'h0000;
      lerr = 1'b0;
    end else begin
      if (inc && vcnt != 16'hFFFF) vcnt++;
      if (er) lerr = 1'b1;
    end
    acc = wr_e;
    @(posedge clk);
    #1;
    rel = rst_n;
  endtask

  // rd_mode: 0 no read, 1 read every cycle, 2 random read gaps.
  task automatic send_word(input logic [31:0] data, input bit last, input int rd_mode);
    bit acc;
    int budget;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = data;
    s_axis.tlast  = last;
    acc    = 1'b0;
    budget = 0;
    while (!acc && budget < 200) begin
      fifo_read = (rd_mode == 2) ? ($urandom_range(0, 3) != 0) : (rd_mode == 1);
      step(acc);
      budget++;
    end
    if (!acc) check("stall_timeout", 32'd1, 32'd0);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input bit last, input int rd_mode);
    for (int i = 0; i < n; i++) begin
      send_word(base + 32'(i), last && (i == n - 1), rd_mode);
    end
  endtask

  task automatic idle(input int n, input bit rd);
    bit acc;
    s_axis.tvalid = 1'b0;
    fifo_read     = rd;
    for (int i = 0; i < n; i++) step(acc);
    fifo_read = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int budget;
    s_axis.tvalid = 1'b0;
    fifo_read     = 1'b1;
    budget        = 0;
    while (sb.size() != 0 && budget < 200) begin
      step(acc);
      budget++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'd1, 32'd0);
    fifo_read = 1'b0;
    step(acc);
  endtask

  // Asynchronous reset taken #1 after an edge; outputs must clear without a clock.
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_tready", 32'(s_axis.tready), 32'd0);
    check("rst_dout", fifo_dout, 32'd0);
    sb.delete();
    beat = 0;
    vcnt = 16'h0000;
    lerr = 1'b0;
    rel  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    rst_n         = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 32'd0;
    s_axis.tlast  = 1'b0;
    fifo_read     = 1'b0;
    err_clr       = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // One exact vector, then pop it back out in order.
    send_pkt(WPV, 32'h0000_0000, 1'b1, 0);
    idle(1, 1'b0);
    check("vec_after_40", 32'(vec_cnt), 32'd1);
    drain();

    // Fill to full, refuse while full, free one slot.
    send_pkt(DEPTH, 32'h0001_0000, 1'b0, 0);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 32'h0001_FFFF;
    fifo_read     = 1'b0;
    step(acc);
    check("full_no_accept", 32'(acc), 32'd0);
    fifo_read = 1'b1;
    step(acc);
    check("full_pop_no_accept", 32'(acc), 32'd0);
    fifo_read = 1'b0;
    check("level_after_pop", 32'(fifo_level), 32'd63);
    step(acc);
    check("accept_after_pop", 32'(acc), 32'd1);
    s_axis.tvalid = 1'b0;
    drain();

    // Long stream with random read gaps across pointer wrap.
    for (int i = 0; i < 200; i++) begin
      send_word(32'hA500_0000 + 32'(i * 7), 1'b0, 2);
    end
    drain();

    // Concurrent read and write at level 10.
    send_pkt(10, 32'h0002_0000, 1'b0, 0);
    send_pkt(20, 32'h0002_0100, 1'b0, 1);
    check("level_concurrent", 32'(fifo_level), 32'd10);
    drain();

    // Framing: short packet, good packet, clear.
    apply_reset();
    send_pkt(25, 32'h0003_0000, 1'b1, 1);
    send_pkt(WPV, 32'h0003_0100, 1'b1, 1);
    idle(1, 1'b1);
    check("err_sticky", 32'(len_err), 32'd1);
    check("vec_after_err", 32'(vec_cnt), 32'd1);
    err_clr = 1'b1;
    idle(1, 1'b0);
    err_clr = 1'b0;
    idle(1, 1'b0);
    check("clr_err", 32'(len_err), 32'd0);
    check("clr_vec", 32'(vec_cnt), 32'd0);

    // Two vectors in one packet, then reads on an empty FIFO.
    send_pkt(2 * WPV, 32'h0004_0000, 1'b1, 1);
    drain();
    check("vec_multi", 32'(vec_cnt), 32'd2);
    idle(3, 1'b1);
    check("empty_read_level", 32'(fifo_level), 32'd0);

    // Reset mid-packet at level 17, then a clean vector.
    send_pkt(17, 32'h0005_0000, 1'b0, 0);
    check("level_17", 32'(fifo_level), 32'd17);
    apply_reset();
    idle(1, 1'b0);
    send_pkt(WPV, 32'h0006_0000, 1'b1, 0);
    idle(1, 1'b0);
    check("vec_after_reset", 32'(vec_cnt), 32'd1);
    check("err_after_reset", 32'(len_err), 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
